// File: rtl/node_serdes_mac.sv
// node_serdes_mac
// End-node MAC/PHY sitting between a node's frame-queue/send controller and
// one port of the L2 switch. One instance per node.
//
// TX: a 16-bit frame offered with a 1-cycle frame_tx_valid pulse is latched
//     and sent MSB-first on tx_bit, followed by IFG_CYCLES forced-idle cycles.
//     Requests that arrive while busy are dropped and counted.
// RX: rx_bit is scanned for the 4-bit SFD. The 12 bits after it are
//     collected and filtered on DST (own address, broadcast, or promiscuous).
//     Accepted frames are presented on rx_frame with a 1-cycle valid pulse.
//
// Ports:
//   FPGA_CLK        clock
//   sys_rst         asynchronous active-high reset
//   tx_frame[15:0]  {SFD, DST, SRC, PAYLOAD}, sampled only when accepted
//   frame_tx_valid  1-cycle transmit request
//   tx_busy         high while serializing or in the inter-frame gap
//   tx_bit          serial line to the switch, idles at 0
//   rx_bit          serial line from the switch
//   rx_frame[15:0]  last accepted frame, held until the next accept
//   frame_rx_valid  1-cycle pulse per accepted frame
//   rx_ok_cnt       accepted frames (saturating)
//   rx_drop_cnt     frames rejected by the address filter (saturating)
//   tx_reject_cnt   transmit requests ignored while busy (saturating)
module node_serdes_mac #(
    parameter logic [3:0] MAC_ADDRESS = 4'hA,
    parameter logic [3:0] SFD         = 4'b0101,
    parameter logic [3:0] BCAST_ADDR  = 4'hF,
    parameter int         IFG_CYCLES  = 4,
    parameter bit         PROMISC     = 1'b0
) (
    input  logic        FPGA_CLK,
    input  logic        sys_rst,
    input  logic [15:0] tx_frame,
    input  logic        frame_tx_valid,
    output logic        tx_busy,
    output logic        tx_bit,
    input  logic        rx_bit,
    output logic [15:0] rx_frame,
    output logic        frame_rx_valid,
    output logic [7:0]  rx_ok_cnt,
    output logic [7:0]  rx_drop_cnt,
    output logic [7:0]  tx_reject_cnt
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SHIFT = 2'd1;
    localparam logic [1:0] TX_IFG   = 2'd2;

    localparam logic [0:0] RX_HUNT    = 1'b0;
    localparam logic [0:0] RX_COLLECT = 1'b1;

    localparam logic [3:0] IFG_LAST = 4'(IFG_CYCLES - 1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [1:0]  tx_state_reg, tx_state_next;
    logic [14:0] tx_shift_reg, tx_shift_next;   // bits still to send, MSB next
    logic [3:0]  tx_cnt_reg,   tx_cnt_next;     // SHIFT: bits left after current; IFG: cycles left after current
    logic        tx_bit_reg,   tx_bit_next;
    logic        tx_ready;
    logic        tx_reject;

    // A new frame may be taken in idle, or on the edge that ends the last gap cycle.
    assign tx_ready = (tx_state_reg == TX_IDLE) ||
                      ((tx_state_reg == TX_IFG) && (tx_cnt_reg == 4'd0));

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_reject     = 1'b0;

        case (tx_state_reg)
            TX_SHIFT: begin
                if (tx_cnt_reg == 4'd0) begin
                    tx_state_next = TX_IFG;
                    tx_cnt_next   = IFG_LAST;
                    tx_bit_next   = 1'b0;
                end else begin
                    tx_bit_next   = tx_shift_reg[14];
                    tx_shift_next = {tx_shift_reg[13:0], 1'b0};
                    tx_cnt_next   = tx_cnt_reg - 4'd1;
                end
            end
            TX_IFG: begin
                tx_bit_next = 1'b0;
                if (tx_cnt_reg == 4'd0) begin
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt_reg - 4'd1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
                tx_bit_next   = 1'b0;
            end
        endcase

        // The first bit goes straight into the output register so it is on
        // the line in the cycle right after the accepting edge.
        if (frame_tx_valid) begin
            if (tx_ready) begin
                tx_state_next = TX_SHIFT;
                tx_bit_next   = tx_frame[15];
                tx_shift_next = tx_frame[14:0];
                tx_cnt_next   = 4'd15;
            end else begin
                tx_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
        end
    end

    assign tx_bit  = tx_bit_reg;
    assign tx_busy = (tx_state_reg != TX_IDLE);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [0:0]  rx_state_reg, rx_state_next;
    logic [2:0]  rx_window_reg, rx_window_next;  // previous three line bits; the fourth is rx_bit itself
    logic [10:0] rx_data_reg,   rx_data_next;
    logic [3:0]  rx_cnt_reg,    rx_cnt_next;
    logic [15:0] rx_frame_reg,  rx_frame_next;
    logic        rx_valid_reg,  rx_valid_next;
    logic [15:0] rx_word;
    logic        rx_addr_match;
    logic        rx_ok_inc;
    logic        rx_drop_inc;

    // Complete frame as it stands on the edge that samples the 12th data bit.
    assign rx_word       = {SFD, rx_data_reg, rx_bit};
    assign rx_addr_match = PROMISC ||
                           (rx_word[11:8] == MAC_ADDRESS) ||
                           (rx_word[11:8] == BCAST_ADDR);

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_window_next = rx_window_reg;
        rx_data_next   = rx_data_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_frame_next  = rx_frame_reg;
        rx_valid_next  = 1'b0;
        rx_ok_inc      = 1'b0;
        rx_drop_inc    = 1'b0;

        case (rx_state_reg)
            RX_COLLECT: begin
                rx_data_next = {rx_data_reg[9:0], rx_bit};
                rx_cnt_next  = rx_cnt_reg + 4'd1;
                if (rx_cnt_reg == 4'd11) begin
                    if (rx_addr_match) begin
                        rx_frame_next = rx_word;
                        rx_valid_next = 1'b1;
                        rx_ok_inc     = 1'b1;
                    end else begin
                        rx_drop_inc   = 1'b1;
                    end
                    // Window restarts empty so no frame bit can contribute to the next SFD.
                    rx_state_next  = RX_HUNT;
                    rx_window_next = '0;
                    rx_cnt_next    = 4'd0;
                end
            end
            default: begin
                rx_window_next = {rx_window_reg[1:0], rx_bit};
                if ({rx_window_reg, rx_bit} == SFD) begin
                    rx_state_next  = RX_COLLECT;
                    rx_cnt_next    = 4'd0;
                    rx_window_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state_reg  <= RX_HUNT;
            rx_window_reg <= '0;
            rx_data_reg   <= '0;
            rx_cnt_reg    <= '0;
            rx_frame_reg  <= '0;
            rx_valid_reg  <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_window_reg <= rx_window_next;
            rx_data_reg   <= rx_data_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_frame_reg  <= rx_frame_next;
            rx_valid_reg  <= rx_valid_next;
        end
    end

    assign rx_frame       = rx_frame_reg;
    assign frame_rx_valid = rx_valid_reg;

    // ------------------------------------------------------------------
    // Saturating statistics counters: [0] rx ok, [1] rx drop, [2] tx reject
    // ------------------------------------------------------------------
    logic [2:0]  stat_inc;
    logic [23:0] stat_flat;

    assign stat_inc = {tx_reject, rx_drop_inc, rx_ok_inc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [7:0] stat_cnt_reg;

            always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
                if (sys_rst) begin
                    stat_cnt_reg <= 8'd0;
                end else if (stat_inc[gi] && (stat_cnt_reg != 8'hFF)) begin
                    stat_cnt_reg <= stat_cnt_reg + 8'd1;
                end
            end

            assign stat_flat[gi*8 +: 8] = stat_cnt_reg;
        end
    endgenerate

    assign rx_ok_cnt     = stat_flat[7:0];
    assign rx_drop_cnt   = stat_flat[15:8];
    assign tx_reject_cnt = stat_flat[23:16];

endmodule

// File: tb/tb_node_serdes_mac.sv
// Testbench for node_serdes_mac: loopback and directly-driven RX traffic,
// received frames checked against a scoreboard of expected frames and
// arrival cycles, plus register/counter checks after each transaction.
module tb_node_serdes_mac;

    logic        FPGA_CLK = 1'b0;
    logic        sys_rst;
    logic        prom_rst;
    logic [15:0] tx_frame;
    logic        frame_tx_valid;
    logic        tx_busy;
    logic        tx_bit;
    logic        rx_bit_main;
    logic        rx_drv;
    logic        loop_en;
    logic [15:0] rx_frame;
    logic        frame_rx_valid;
    logic [7:0]  rx_ok_cnt;
    logic [7:0]  rx_drop_cnt;
    logic [7:0]  tx_reject_cnt;

    logic        p_tx_busy;
    logic        p_tx_bit;
    logic [15:0] p_rx_frame;
    logic        p_rx_valid;
    logic [7:0]  p_ok_cnt;
    logic [7:0]  p_drop_cnt;
    logic [7:0]  p_rej_cnt;

    always #5 FPGA_CLK = ~FPGA_CLK;

    assign rx_bit_main = loop_en ? tx_bit : rx_drv;

    node_serdes_mac u_dut (
        .FPGA_CLK       (FPGA_CLK),
        .sys_rst        (sys_rst),
        .tx_frame       (tx_frame),
        .frame_tx_valid (frame_tx_valid),
        .tx_busy        (tx_busy),
        .tx_bit         (tx_bit),
        .rx_bit         (rx_bit_main),
        .rx_frame       (rx_frame),
        .frame_rx_valid (frame_rx_valid),
        .rx_ok_cnt      (rx_ok_cnt),
        .rx_drop_cnt    (rx_drop_cnt),
        .tx_reject_cnt  (tx_reject_cnt)
    );

    node_serdes_mac #(.PROMISC(1'b1)) u_prom (
        .FPGA_CLK       (FPGA_CLK),
        .sys_rst        (prom_rst),
        .tx_frame       (16'h0000),
        .frame_tx_valid (1'b0),
        .tx_busy        (p_tx_busy),
        .tx_bit         (p_tx_bit),
        .rx_bit         (rx_drv),
        .rx_frame       (p_rx_frame),
        .frame_rx_valid (p_rx_valid),
        .rx_ok_cnt      (p_ok_cnt),
        .rx_drop_cnt    (p_drop_cnt),
        .tx_reject_cnt  (p_rej_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int prom_pulses = 0;

    always @(posedge FPGA_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] frame;
        int          due;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [15:0] frame;
        bit          accept;
    } vec_t;

    vec_t vecs[5];

    int          exp_ok;
    int          exp_drop;
    int          exp_rej;
    logic [15:0] exp_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge FPGA_CLK);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".rx_frame"},   32'(rx_frame),      32'(exp_frame));
        check({tag, ".rx_ok_cnt"},  32'(rx_ok_cnt),     32'(exp_ok));
        check({tag, ".rx_drop_cnt"}, 32'(rx_drop_cnt),  32'(exp_drop));
        check({tag, ".tx_reject"},  32'(tx_reject_cnt), 32'(exp_rej));
    endtask

    // Received-frame monitor: every pulse must match the head of the scoreboard.
    always @(negedge FPGA_CLK) begin
        exp_t e;
        if (frame_rx_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got frame %h want no pulse", rx_frame);
            end else begin
                e = sb.pop_front();
                $display("rx pulse frame=%h cycle=%0d", rx_frame, cyc);
                check("rx_pulse_frame",   32'(rx_frame), 32'(e.frame));
                check("rx_pulse_latency", 32'(cyc),      32'(e.due));
            end
        end
        if (p_rx_valid) prom_pulses++;
    end

    // Loopback transmit of one frame, checking every line bit and tx_busy.
    task automatic send_tx(input logic [15:0] frame, input bit accept);
        logic exp_bit;
        tx_frame       = frame;
        frame_tx_valid = 1'b1;
        tick();
        frame_tx_valid = 1'b0;
        if (accept) begin
            sb.push_back('{frame: frame, due: cyc + 16});
            exp_ok++;
            exp_frame = frame;
        end else begin
            exp_drop++;
        end
        $display("tx frame=%h accept_expected=%0d", frame, accept);
        for (int i = 1; i <= 21; i++) begin
            exp_bit = (i <= 16) ? frame[16 - i] : 1'b0;
            check($sformatf("tx_bit[k+%0d]", i), 32'(tx_bit), 32'(exp_bit));
            check($sformatf("tx_busy[k+%0d]", i), 32'(tx_busy), 32'(i <= 20));
            tick();
        end
    endtask

    // Drive n bits of v onto rx_drv, MSB first, one bit per cycle.
    task automatic drive_rx(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rx_drv = v[i];
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{frame: 16'h5AB7, accept: 1'b1};
        vecs[1] = '{frame: 16'h5CB3, accept: 1'b0};
        vecs[2] = '{frame: 16'h5FB1, accept: 1'b1};
        vecs[3] = '{frame: 16'h5A00, accept: 1'b1};
        vecs[4] = '{frame: 16'h53FF, accept: 1'b0};

        sys_rst        = 1'b1;
        prom_rst       = 1'b1;
        loop_en        = 1'b1;
        rx_drv         = 1'b0;
        tx_frame       = 16'h0000;
        frame_tx_valid = 1'b0;
        exp_ok = 0; exp_drop = 0; exp_rej = 0; exp_frame = 16'h0000;

        repeat (3) tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        check("reset.tx_bit",  32'(tx_bit),  32'h0);
        check("reset.tx_busy", 32'(tx_busy), 32'h0);
        check("reset.rx_valid", 32'(frame_rx_valid), 32'h0);
        check_stats("reset");

        // Table-driven loopback frames
        for (int v = 0; v < 5; v++) begin
            send_tx(vecs[v].frame, vecs[v].accept);
            tick();
            check_stats($sformatf("vec%0d", v));
        end

        // Busy reject at k+5, boundary accept at k+20, then idle accept at k+21
        tx_frame = 16'h5A33; frame_tx_valid = 1'b1;
        tick();
        frame_tx_valid = 1'b0;
        sb.push_back('{frame: 16'h5A33, due: cyc + 16});
        exp_ok++; exp_frame = 16'h5A33;
        repeat (4) tick();
        tx_frame = 16'h5A11; frame_tx_valid = 1'b1;
        tick();
        frame_tx_valid = 1'b0;
        exp_rej++;
        $display("tx request rejected while busy");
        check("reject.count", 32'(tx_reject_cnt), 32'(exp_rej));
        repeat (14) tick();
        check("ifg_last.busy", 32'(tx_busy), 32'h1);
        tx_frame = 16'h5A22; frame_tx_valid = 1'b1;
        tick();
        frame_tx_valid = 1'b0;
        sb.push_back('{frame: 16'h5A22, due: cyc + 16});
        exp_ok++; exp_frame = 16'h5A22;
        check("ifg_boundary.no_reject", 32'(tx_reject_cnt), 32'(exp_rej));
        repeat (20) tick();
        check("idle.busy", 32'(tx_busy), 32'h0);
        tx_frame = 16'h5AC5; frame_tx_valid = 1'b1;
        tick();
        frame_tx_valid = 1'b0;
        sb.push_back('{frame: 16'h5AC5, due: cyc + 16});
        exp_ok++; exp_frame = 16'h5AC5;
        repeat (22) tick();
        check_stats("reject_seq");

        // Noise ahead of a frame: only the real SFD starts collection
        loop_en = 1'b0;
        repeat (2) tick();
        drive_rx(16'h001B, 5);
        sb.push_back('{frame: 16'h5A0F, due: cyc + 16});
        exp_ok++; exp_frame = 16'h5A0F;
        drive_rx(16'h5A0F, 16);
        rx_drv = 1'b0;
        repeat (4) tick();
        check_stats("noise");

        // Reset in the middle of an incoming frame
        drive_rx(16'h005A, 8);
        sys_rst = 1'b1;
        #1;
        exp_ok = 0; exp_drop = 0; exp_rej = 0; exp_frame = 16'h0000;
        check("midrst.rx_valid", 32'(frame_rx_valid), 32'h0);
        check_stats("midrst");
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        check("midrst.tx_busy", 32'(tx_busy), 32'h0);
        check_stats("after_rst");
        sb.push_back('{frame: 16'h5A66, due: cyc + 16});
        exp_ok++; exp_frame = 16'h5A66;
        drive_rx(16'h5A66, 16);
        rx_drv = 1'b0;
        repeat (4) tick();
        check_stats("post_rst_frame");

        // Promiscuous instance accepts DST=3; the normal instance drops it
        prom_rst = 1'b0;
        tick();
        exp_drop++;
        drive_rx(16'h53C4, 16);
        rx_drv = 1'b0;
        repeat (4) tick();
        check("prom.rx_frame", 32'(p_rx_frame), 32'h53C4);
        check("prom.ok_cnt",   32'(p_ok_cnt),   32'h1);
        check("prom.drop_cnt", 32'(p_drop_cnt), 32'h0);
        check("prom.pulses",   32'(prom_pulses), 32'h1);
        check("prom.tx_idle",  32'({p_tx_busy, p_tx_bit, p_rej_cnt}), 32'h0);
        check_stats("normal_drop");

        // Reject counter saturation: hold the request high across many frames
        tx_frame       = 16'h0000;
        frame_tx_valid = 1'b1;
        repeat (400) tick();
        frame_tx_valid = 1'b0;
        repeat (25) tick();
        check("reject.saturate", 32'(tx_reject_cnt), 32'd255);

        check("scoreboard.empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
